// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter between an instruction cache (read-only)
// and a data cache (read/write) sharing one fixed-latency memory port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
// Ports:
//   clock, reset                       rising-edge clock, async active-high reset
//   icache_req/_address                instruction-cache read request
//   icache_ready/_data                 one-cycle completion pulse, returned line
//   dcache_req/_write/_address/_data_in data-cache request (write when _write=1)
//   dcache_ready/_data                 one-cycle completion pulse, returned read line
//   mem_write_enable/_read_enable      one-cycle strobes to memory during ISSUE
//   mem_address/mem_data_in            latched request address / write line
//   mem_data_out                       line returned by memory
//   busy                               high whenever the FSM is not IDLE
module memory_arbiter #(
  parameter int unsigned ADDRESS_SIZE    = 12,
  parameter int unsigned CACHE_LINE_SIZE = 128,
  parameter int unsigned MEMORY_LATENCY  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       icache_req,
  input  logic [ADDRESS_SIZE-1:0]    icache_address,
  output logic                       icache_ready,
  output logic [CACHE_LINE_SIZE-1:0] icache_data,
  input  logic                       dcache_req,
  input  logic                       dcache_write,
  input  logic [ADDRESS_SIZE-1:0]    dcache_address,
  input  logic [CACHE_LINE_SIZE-1:0] dcache_data_in,
  output logic                       dcache_ready,
  output logic [CACHE_LINE_SIZE-1:0] dcache_data,
  output logic                       mem_write_enable,
  output logic                       mem_read_enable,
  output logic [ADDRESS_SIZE-1:0]    mem_address,
  output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
  input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
  output logic                       busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic             last_d;    // 1: dcache received the most recent grant
  logic             grant_d;   // port currently being serviced (1 = dcache)
  logic             is_write;  // current transaction is a dcache write
  logic             any_req;
  logic             pick_d;

  // Arbitration and next-state logic
  always_comb begin
    next_state = state;
    any_req    = icache_req | dcache_req;
    // dcache wins when alone, or on a tie when icache was granted last
    pick_d     = dcache_req & (~icache_req | ~last_d);
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (count <= CNT_W'(1)) next_state = RESPOND;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Request latching, memory strobes, latency counter and response outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count            <= '0;
      last_d           <= 1'b1;
      grant_d          <= 1'b0;
      is_write         <= 1'b0;
      icache_ready     <= 1'b0;
      icache_data      <= '0;
      dcache_ready     <= 1'b0;
      dcache_data      <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      busy             <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      icache_ready     <= 1'b0;
      dcache_ready     <= 1'b0;
      busy             <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d          <= pick_d;
            last_d           <= pick_d;
            is_write         <= pick_d & dcache_write;
            mem_address      <= pick_d ? dcache_address : icache_address;
            if (pick_d) mem_data_in <= dcache_data_in;
            // strobes are registered here so they are high exactly during ISSUE
            mem_write_enable <= pick_d & dcache_write;
            mem_read_enable  <= ~(pick_d & dcache_write);
          end
        end
        ISSUE: count <= CNT_W'(MEMORY_LATENCY);
        WAIT: begin
          count <= count - CNT_W'(1);
          if (next_state == RESPOND) begin
            if (grant_d) dcache_ready <= 1'b1;
            else         icache_ready <= 1'b1;
            if (!is_write) begin
              if (grant_d) dcache_data <= mem_data_out;
              else         icache_data <= mem_data_out;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: scoreboard of expected ready pulses (port,
// data, cycle) checked by a forked monitor, plus directed checks of memory
// strobes, busy gaps, reset behaviour and a latency-1 instance.
module tb_memory_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 128;
  localparam int          LAT = 4;

  localparam logic [DW-1:0] P1    = 128'h11112222333344445555666677778888;
  localparam logic [DW-1:0] P3    = 128'h3333aaaa3333aaaa3333aaaa3333aaaa;
  localparam logic [DW-1:0] P4    = 128'h4444bbbb4444bbbb4444bbbb4444bbbb;
  localparam logic [DW-1:0] P5    = 128'h5555cccc5555cccc5555cccc5555cccc;
  localparam logic [DW-1:0] P6    = 128'h6666dddd6666dddd6666dddd6666dddd;
  localparam logic [DW-1:0] P7    = 128'h7777eeee7777eeee7777eeee7777eeee;
  localparam logic [DW-1:0] WDATA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] PAT   = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          icache_req = 1'b0, dcache_req = 1'b0, dcache_write = 1'b0;
  logic [AW-1:0] icache_address = '0, dcache_address = '0;
  logic [DW-1:0] dcache_data_in = '0;
  logic          icache_ready, dcache_ready, mem_write_enable, mem_read_enable, busy;
  logic [DW-1:0] icache_data, dcache_data, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_address;

  // latency-1 instance, icache side only
  logic          icache_req1 = 1'b0;
  logic [AW-1:0] icache_address1 = '0;
  logic          zero1 = 1'b0;
  logic [AW-1:0] zero_a = '0;
  logic [DW-1:0] zero_d = '0;
  logic          icache_ready1, dcache_ready1, mem_write_enable1, mem_read_enable1, busy1;
  logic [DW-1:0] icache_data1, dcache_data1, mem_data_in1, mem_data_out1;
  logic [AW-1:0] mem_address1;

  always #5 clock = ~clock;

  memory_arbiter #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(DW), .MEMORY_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .icache_req(icache_req), .icache_address(icache_address),
    .icache_ready(icache_ready), .icache_data(icache_data),
    .dcache_req(dcache_req), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_data_in(dcache_data_in),
    .dcache_ready(dcache_ready), .dcache_data(dcache_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy));

  memory_arbiter #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(DW), .MEMORY_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset),
    .icache_req(icache_req1), .icache_address(icache_address1),
    .icache_ready(icache_ready1), .icache_data(icache_data1),
    .dcache_req(zero1), .dcache_write(zero1),
    .dcache_address(zero_a), .dcache_data_in(zero_d),
    .dcache_ready(dcache_ready1), .dcache_data(dcache_data1),
    .mem_write_enable(mem_write_enable1), .mem_read_enable(mem_read_enable1),
    .mem_address(mem_address1), .mem_data_in(mem_data_in1),
    .mem_data_out(mem_data_out1), .busy(busy1));

  // Memory model: combinational read, write on the edge closing ISSUE, preload under reset
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign mem_data_out  = mem[mem_address];
  assign mem_data_out1 = PAT ^ DW'(mem_address1);
  always @(posedge clock) begin
    if (reset) begin
      mem[12'h010] <= P1;
      mem[12'h030] <= P3;
      mem[12'h040] <= P4;
      mem[12'h050] <= P5;
      mem[12'h060] <= P6;
      mem[12'h070] <= P7;
    end else if (mem_write_enable) begin
      mem[mem_address] <= mem_data_in;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic          port;   // 1 = dcache
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] dc_model = '0;

  task automatic chk1(input string name, input logic act, input logic want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", name, act, want);
    end
  endtask

  task automatic chki(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic chkv(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Monitor: every ready pulse must match the head of the scoreboard
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (icache_ready || dcache_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ready: ready seen at cycle %0d, none required", cyc);
        end else begin
          e = sb.pop_front();
          chk1("ready_port", dcache_ready, e.port);
          chk1("ready_both", icache_ready & dcache_ready, 1'b0);
          chkv("ready_data", e.port ? dcache_data : icache_data, e.data);
          chki("ready_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_iready"}, icache_ready, 1'b0);
    chk1({tag, "_dready"}, dcache_ready, 1'b0);
    chk1({tag, "_we"}, mem_write_enable, 1'b0);
    chk1({tag, "_re"}, mem_read_enable, 1'b0);
    chki({tag, "_addr"}, int'(mem_address), 0);
    chkv({tag, "_mdin"}, mem_data_in, '0);
    chkv({tag, "_idata"}, icache_data, '0);
    chkv({tag, "_ddata"}, dcache_data, '0);
  endtask

  // Single-requester transaction; also checks the ISSUE-cycle memory strobes
  task automatic run_txn(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] want, input string tag);
    int rd = 0, wrc = 0, rd_k = 0;
    logic [AW-1:0] a_seen = '0;
    logic [DW-1:0] d_seen = '0;
    sb.push_back('{port: is_d, data: want, cyc: cyc + LAT + 2});
    if (is_d) begin
      dcache_req = 1'b1; dcache_write = wr; dcache_address = addr; dcache_data_in = wdata;
    end else begin
      icache_req = 1'b1; icache_address = addr;
    end
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clock);
      if (mem_read_enable) begin rd++; rd_k = k; a_seen = mem_address; end
      if (mem_write_enable) begin wrc++; a_seen = mem_address; d_seen = mem_data_in; end
    end
    icache_req = 1'b0; dcache_req = 1'b0; dcache_write = 1'b0;
    chki({tag, "_rd_pulses"}, rd, wr ? 0 : 1);
    chki({tag, "_wr_pulses"}, wrc, wr ? 1 : 0);
    chki({tag, "_mem_addr"}, int'(a_seen), int'(addr));
    if (wr) chkv({tag, "_mem_wdata"}, d_seen, wdata);
    else    chki({tag, "_rd_cycle"}, rd_k, 1);
    @(negedge clock);
  endtask

  initial begin
    int c0, rd, busy_low, rk, cnt;
    int rd_k[2];
    logic [AW-1:0] rd_a[2];
    logic [DW-1:0] d1;
    fork monitor(); join_none

    // reset state
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    // icache read of a preloaded line
    run_txn(1'b0, 1'b0, 12'h010, '0, P1, "iread");

    // dcache write, then read back; write leaves dcache_data untouched
    run_txn(1'b1, 1'b1, 12'h020, WDATA, dc_model, "dwrite");
    run_txn(1'b1, 1'b0, 12'h020, '0, WDATA, "dread");
    dc_model = WDATA;

    // simultaneous requests straight after reset: icache first
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    c0 = cyc; rd = 0;
    sb.push_back('{port: 1'b0, data: P3, cyc: c0 + 6});
    sb.push_back('{port: 1'b1, data: P4, cyc: c0 + 13});
    icache_req = 1'b1; icache_address = 12'h030;
    dcache_req = 1'b1; dcache_write = 1'b0; dcache_address = 12'h040;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clock);
      if (mem_read_enable) begin
        if (rd < 2) begin rd_k[rd] = k; rd_a[rd] = mem_address; end
        rd++;
      end
      if (k == 6) icache_req = 1'b0;
    end
    dcache_req = 1'b0;
    chki("tie_rd_pulses", rd, 2);
    chki("tie_first_k", rd_k[0], 1);
    chki("tie_first_addr", int'(rd_a[0]), 12'h030);
    chki("tie_second_k", rd_k[1], 8);
    chki("tie_second_addr", int'(rd_a[1]), 12'h040);
    @(negedge clock);

    // both requesting continuously: I, D, I, D with one idle cycle between
    c0 = cyc; rd = 0; busy_low = 0;
    sb.push_back('{port: 1'b0, data: P5, cyc: c0 + 6});
    sb.push_back('{port: 1'b1, data: P6, cyc: c0 + 13});
    sb.push_back('{port: 1'b0, data: P5, cyc: c0 + 20});
    sb.push_back('{port: 1'b1, data: P6, cyc: c0 + 27});
    icache_req = 1'b1; icache_address = 12'h050;
    dcache_req = 1'b1; dcache_address = 12'h060;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clock);
      if (!busy) busy_low++;
      if (mem_read_enable) rd++;
    end
    icache_req = 1'b0; dcache_req = 1'b0;
    chki("rr_busy_low_cycles", busy_low, 3);
    chki("rr_rd_pulses", rd, 4);
    @(negedge clock);

    // reset during WAIT: outputs clear at once, no ready, then nominal recovery
    icache_req = 1'b1; icache_address = 12'h070;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k == 2) chk1("wait_busy", busy, 1'b1);
    end
    reset = 1'b1; icache_req = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    dc_model = '0;
    run_txn(1'b0, 1'b0, 12'h070, '0, P7, "recover");

    // latency-1 instance: ready two edges after grant
    cnt = 0; rk = 0; d1 = '0;
    icache_req1 = 1'b1; icache_address1 = 12'h0AB;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk1("l1_re", mem_read_enable1, 1'b1);
        chk1("l1_busy", busy1, 1'b1);
      end
      if (mem_write_enable1 || dcache_ready1) cnt = cnt + 100;
      if (icache_ready1) begin cnt++; rk = k; d1 = icache_data1; end
      if (k == 3) icache_req1 = 1'b0;
    end
    chki("l1_ready_pulses", cnt, 1);
    chki("l1_ready_k", rk, 3);
    chkv("l1_data", d1, PAT ^ DW'(12'h0AB));
    chkv("l1_ddata", dcache_data1, '0);
    chkv("l1_mdin", mem_data_in1, '0);

    repeat (3) @(negedge clock);
    chki("pending_responses", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
